lsq_mem_arbiter: RTL and testbench

Single-port data-memory scheduler between the Load_Store_Queue and data memory. Two requesters share the port: speculative loads issued by the LSQ, and committed stores drained from the retire side. The block arbitrates between them with a store-starvation guard, sequences each access through a request/wait state machine, and returns load data to the writeback path tagged with ROB number and destination register. Loads can be squashed by a pipeline flush; stores are never squashed.

---
 rtl/lsq_mem_arbiter_if.sv | 56 +++++
 rtl/lsq_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_lsq_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsq_mem_arbiter_if.sv
// Port bundle between the LSQ/store drain, data memory and writeback.
// The arbiter takes the slave side; the environment drives the master side.
interface lsq_mem_arbiter_if;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [5:0]  ld_rob;
  logic [5:0]  ld_dest;
  logic        ld_ready;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_size;
  logic        st_full_hint;
  logic        st_ready;
  logic        flush;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_size;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        wb_valid;
  logic [5:0]  wb_rob;
  logic [5:0]  wb_dest;
  logic [31:0] wb_data;
  logic        busy;

  modport slave (
    input  ld_valid, ld_addr, ld_rob, ld_dest,
    output ld_ready,
    input  st_valid, st_addr, st_data, st_size,
    input  st_full_hint,
    output st_ready,
    input  flush,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output mem_size,
    input  mem_rdata, mem_done,
    output wb_valid, wb_rob, wb_dest, wb_data,
    output busy
  );

  modport master (
    output ld_valid, ld_addr, ld_rob, ld_dest,
    input  ld_ready,
    output st_valid, st_addr, st_data, st_size,
    output st_full_hint,
    input  st_ready,
    output flush,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_size,
    output mem_rdata, mem_done,
    input  wb_valid, wb_rob, wb_dest, wb_data,
    input  busy
  );
endinterface

// File: rtl/lsq_mem_arbiter.sv
// Single-port data-memory scheduler: loads vs committed stores,
// with a store-starvation guard and flush-squashed load results.
module lsq_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input logic               clk,
  input logic               rst,
  lsq_mem_arbiter_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t      state_q, state_d;
  logic        op_st_q, op_st_d;
  logic        kill_q, kill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        size_q, size_d;
  logic [5:0]  rob_q, rob_d;
  logic [5:0]  dest_q, dest_d;
  logic        wb_valid_q, wb_valid_d;
  logic [5:0]  wb_rob_q, wb_rob_d;
  logic [5:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic idle, starved, ld_ok;
  logic pick_st, pick_ld;
  logic ld_go, st_go;

  // Priority: full hint, starvation, live load, then any store.
  always_comb begin
    idle    = (state_q == IDLE);
    starved = (cnt_q == CNT_W'(STARVE_MAX));
    ld_ok   = io.ld_valid & ~io.flush;
    pick_st = io.st_valid &
              (io.st_full_hint | starved | ~ld_ok);
    pick_ld = ~pick_st & ld_ok;
  end

  assign io.ld_ready = idle & pick_ld;
  assign io.st_ready = idle & pick_st;
  assign ld_go = io.ld_valid & io.ld_ready;
  assign st_go = io.st_valid & io.st_ready;

  always_comb begin
    state_d    = state_q;
    op_st_d    = op_st_q;
    kill_d     = kill_q;
    cnt_d      = cnt_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    rob_d      = rob_q;
    dest_d     = dest_q;
    wb_valid_d = 1'b0;
    wb_rob_d   = wb_rob_q;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;

    if (!idle && !op_st_q && io.flush)
      kill_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (st_go) begin
          state_d  = REQ;
          op_st_d  = 1'b1;
          addr_d   = io.st_addr;
          wdata_d  = io.st_data;
          size_d   = io.st_size;
          mem_en_d = 1'b1;
          mem_we_d = 1'b1;
          cnt_d    = '0;
        end else if (ld_go) begin
          state_d  = REQ;
          op_st_d  = 1'b0;
          addr_d   = io.ld_addr;
          size_d   = 1'b0;
          rob_d    = io.ld_rob;
          dest_d   = io.ld_dest;
          mem_en_d = 1'b1;
          if (io.st_valid && !starved)
            cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (io.mem_done) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          // A flush landing with mem_done still squashes.
          if (!op_st_q && !kill_q && !io.flush) begin
            wb_valid_d = 1'b1;
            wb_rob_d   = rob_q;
            wb_dest_d  = dest_q;
            wb_data_d  = io.mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_st_q    <= 1'b0;
      kill_q     <= 1'b0;
      cnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 1'b0;
      rob_q      <= '0;
      dest_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rob_q   <= '0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_st_q    <= op_st_d;
      kill_q     <= kill_d;
      cnt_q      <= cnt_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      rob_q      <= rob_d;
      dest_q     <= dest_d;
      wb_valid_q <= wb_valid_d;
      wb_rob_q   <= wb_rob_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign io.mem_en    = mem_en_q;
  assign io.mem_we    = mem_we_q;
  assign io.mem_addr  = addr_q;
  assign io.mem_wdata = wdata_q;
  assign io.mem_size  = size_q;
  assign io.wb_valid  = wb_valid_q;
  assign io.wb_rob    = wb_rob_q;
  assign io.wb_dest   = wb_dest_q;
  assign io.wb_data   = wb_data_q;
  assign io.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Scoreboard bench for lsq_mem_arbiter: a transaction-level model
// queues expected accesses/results; a monitor pops and compares.
module tb_lsq_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsq_mem_arbiter_if io();

  lsq_mem_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        size;
  } mem_exp_t;

  typedef struct {
    int          cyc;
    logic [5:0]  rob;
    logic [5:0]  dest;
    logic [31:0] data;
  } wb_exp_t;

  mem_exp_t mem_q[$];
  wb_exp_t  wb_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic        ld_v = 0, st_v = 0, hint = 0;
  logic        fl = 0, rst_v = 1;
  logic [31:0] ld_a = 0, st_a = 0, st_d = 0;
  logic [5:0]  ld_r = 0, ld_dst = 0;
  logic        st_s = 0;
  int          lat_fix = -1;
  logic        rd_fix = 0;
  logic [31:0] rd_val = 0;

  // Transaction-level model of the port occupancy.
  int    free_at = 0, acc_at = -10, done_at = -10;
  int    starve = 0;
  bit    act = 0, act_ld = 0, killed = 0;
  logic [5:0] act_rob, act_dest;
  bit    got_ld, got_st;
  string grants = "";

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic bad(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cyc %0d)", nm, cyc);
  endtask

  task automatic step();
    bit idle, done_now, spur, exp_ld, exp_st;
    int lat;
    cyc++;
    idle     = (cyc >= free_at);
    done_now = act && (cyc == done_at) && !rst_v;
    spur     = !done_now && !rst_v &&
               (!act || cyc == acc_at + 1) &&
               ($urandom_range(0, 3) == 0);
    rst              = rst_v;
    io.ld_valid      = ld_v;
    io.ld_addr       = ld_a;
    io.ld_rob        = ld_r;
    io.ld_dest       = ld_dst;
    io.st_valid      = st_v;
    io.st_addr       = st_a;
    io.st_data       = st_d;
    io.st_size       = st_s;
    io.st_full_hint  = hint;
    io.flush         = fl;
    io.mem_done      = done_now || spur;
    io.mem_rdata     = $urandom;
    if (done_now && rd_fix) io.mem_rdata = rd_val;
    if (act && act_ld && fl && cyc > acc_at)
      killed = 1;
    if (done_now) begin
      if (act_ld && !killed)
        wb_q.push_back('{cyc, act_rob, act_dest,
                         io.mem_rdata});
      act = 0;
    end
    #1;
    got_ld = 0;
    got_st = 0;
    if (rst_v) begin
      act = 0;
      killed = 0;
      free_at = cyc + 1;
      starve = 0;
      return;
    end
    exp_st = idle && st_v &&
             (starve == 4 || hint || !(ld_v && !fl));
    exp_ld = idle && !exp_st && ld_v && !fl;
    chk("ld_ready", io.ld_ready, exp_ld);
    chk("st_ready", io.st_ready, exp_st);
    chk("busy", io.busy, !idle);
    if (exp_st || exp_ld) begin
      lat = (lat_fix >= 2) ? lat_fix
                           : 2 + $urandom_range(0, 3);
      acc_at  = cyc;
      done_at = cyc + lat;
      free_at = done_at + 1;
      act     = 1;
      act_ld  = exp_ld;
      killed  = 0;
      if (exp_st) begin
        mem_q.push_back('{cyc, 1'b1, st_a, st_d, st_s});
        starve = 0;
        got_st = 1;
        grants = {grants, "S"};
      end else begin
        mem_q.push_back('{cyc, 1'b0, ld_a, 32'h0, 1'b0});
        act_rob  = ld_r;
        act_dest = ld_dst;
        if (st_v && starve < 4) starve++;
        got_ld = 1;
        grants = {grants, "L"};
      end
    end
  endtask

  // Monitor: compares registered outputs after each rising edge.
  initial begin
    mem_exp_t me;
    wb_exp_t  we;
    forever begin
      @(posedge clk);
      #2;
      if (io.mem_en === 1'b1) begin
        if (mem_q.size() == 0) begin
          bad("mem_en unexpected");
        end else begin
          me = mem_q.pop_front();
          chk("mem_cyc", cyc, me.cyc);
          chk("mem_we", io.mem_we, me.we);
          chk("mem_addr", io.mem_addr, me.addr);
          chk("mem_size", io.mem_size, me.size);
          if (me.we) chk("mem_wdata", io.mem_wdata, me.wdata);
        end
      end else if (mem_q.size() != 0 && mem_q[0].cyc < cyc) begin
        bad("mem_en missing");
        void'(mem_q.pop_front());
      end
      if (io.wb_valid === 1'b1) begin
        if (wb_q.size() == 0) begin
          bad("wb_valid unexpected");
        end else begin
          we = wb_q.pop_front();
          chk("wb_cyc", cyc, we.cyc);
          chk("wb_rob", io.wb_rob, we.rob);
          chk("wb_dest", io.wb_dest, we.dest);
          chk("wb_data", io.wb_data, we.data);
        end
      end else if (wb_q.size() != 0 && wb_q[0].cyc < cyc) begin
        bad("wb_valid missing");
        void'(wb_q.pop_front());
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_mem_en", io.mem_en, 0);
    chk("rst_mem_we", io.mem_we, 0);
    chk("rst_mem_addr", io.mem_addr, 0);
    chk("rst_mem_wdata", io.mem_wdata, 0);
    chk("rst_mem_size", io.mem_size, 0);
    chk("rst_wb_valid", io.wb_valid, 0);
    chk("rst_wb_rob", io.wb_rob, 0);
    chk("rst_wb_dest", io.wb_dest, 0);
    chk("rst_wb_data", io.wb_data, 0);
    chk("rst_busy", io.busy, 0);
  endtask

  task automatic drain();
    int k = 0;
    ld_v = 0;
    st_v = 0;
    hint = 0;
    fl = 0;
    do begin
      @(negedge clk);
      step();
      k++;
    end while (cyc < free_at + 1 && k < 30);
    if (k >= 30) bad("drain timeout");
  endtask

  // One access; fl_off pulses flush that many cycles after accept.
  task automatic issue(bit is_st, int lat, int fl_off);
    int k = 0;
    lat_fix = lat;
    ld_v = !is_st;
    st_v = is_st;
    do begin
      @(negedge clk);
      step();
      k++;
    end while (!got_ld && !got_st && k < 20);
    if (k >= 20) bad("accept timeout");
    ld_v = 0;
    st_v = 0;
    for (int j = 1; j <= lat + 1; j++) begin
      @(negedge clk);
      fl = (j == fl_off);
      step();
    end
    fl = 0;
    lat_fix = -1;
  endtask

  task automatic run(int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!ld_v && (!rnd || $urandom_range(0, 2) != 0)) begin
        ld_v   = 1;
        ld_a   = $urandom & 32'hffff_fffc;
        ld_r   = 6'($urandom);
        ld_dst = 6'($urandom);
      end
      if (!st_v && (!rnd || $urandom_range(0, 2) == 0)) begin
        st_v = 1;
        st_a = $urandom;
        st_d = $urandom;
        st_s = 1'($urandom);
      end
      if (rnd) begin
        hint = ($urandom_range(0, 5) == 0);
        fl   = ($urandom_range(0, 7) == 0);
      end
      step();
      if (got_ld) ld_v = 0;
      if (got_st) st_v = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      step();
    end
    rst_v = 0;
    @(negedge clk);
    step();
    chk_reset_vals();

    // Single load, done two cycles after mem_en.
    ld_a = 32'h4; ld_r = 6'd5; ld_dst = 6'd12;
    rd_fix = 1; rd_val = 32'h23;
    issue(0, 3, 0);
    rd_fix = 0;
    drain();
    chk("ld_wb_rob", io.wb_rob, 5);
    chk("ld_wb_dest", io.wb_dest, 12);
    chk("ld_wb_data", io.wb_data, 32'h23);

    // Single byte store.
    st_a = 32'h8; st_d = 32'h46; st_s = 1;
    issue(1, 2, 0);
    drain();

    // Starvation: both sides always requesting.
    grants = "";
    run(60, 0);
    chk("starve_seq",
        (grants.substr(0, 9) == "LLLLSLLLLS"), 1);
    drain();

    // Full hint forces the store.
    ld_v = 1; st_v = 1; hint = 1;
    @(negedge clk);
    step();
    chk("hint_st", got_st, 1);
    drain();

    // Flush in idle blocks the load.
    ld_v = 1; fl = 1;
    @(negedge clk);
    step();
    chk("flush_idle_ld", got_ld, 0);
    fl = 0;

    // Flush during WAIT, then on the mem_done cycle.
    ld_a = 32'h40; ld_r = 6'd7; ld_dst = 6'd9;
    issue(0, 4, 2);
    drain();
    issue(0, 4, 4);
    drain();

    // Reset in the middle of WAIT.
    lat_fix = 6;
    ld_v = 1; ld_a = 32'h80;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step();
      if (got_ld) ld_v = 0;
    end
    rst_v = 1;
    @(negedge clk);
    step();
    rst_v = 0;
    ld_v = 0;
    @(negedge clk);
    step();
    chk_reset_vals();
    lat_fix = -1;
    ld_a = 32'hc; ld_r = 6'd33; ld_dst = 6'd44;
    issue(0, 2, 0);
    drain();
    chk("post_rst_wb_rob", io.wb_rob, 33);

    run(2000, 1);
    drain();
    chk("mem_q_empty", mem_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout (cyc %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
